keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan_if.sv | 36 +++
 rtl/keypad_scan.sv | 185 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - matrix drive/sense and key report signals for keypad_scan
//
// Signals:
//   Rows   - active-low one-cold row drive to the 4x4 matrix
//   Cols   - active-low column sense lines (asynchronous, pulled up)
//   Key    - code of the last accepted key (row*4+col)
//   Strobe - one-cycle pulse per accepted press
//   Held   - accepted key is considered down
//   Multi  - most recent frame had more than one key down
// Modports: master = scanner side, slave = matrix / consumer side.
interface keypad_scan_if;
    logic [3:0] Rows;
    logic [3:0] Cols;
    logic [3:0] Key;
    logic       Strobe;
    logic       Held;
    logic       Multi;

    modport master (
        output Rows,
        output Key,
        output Strobe,
        output Held,
        output Multi,
        input  Cols
    );

    modport slave (
        input  Rows,
        input  Key,
        input  Strobe,
        input  Held,
        input  Multi,
        output Cols
    );
endinterface

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad matrix scanner with frame-based debounce
//
// Parameters:
//   ClockPeriod_ns  - Clock period in ns
//   ScanTime_ns     - duration of one full 4-row frame in ns
//   DebounceFrames  - consecutive consistent frames to accept press/release (>= 1)
// Ports:
//   Clock  - rising-edge clock
//   ResetN - asynchronous active-low reset
//   kp     - keypad_scan_if.master (Rows, Cols, Key, Strobe, Held, Multi)
module keypad_scan #(
    parameter int ClockPeriod_ns = 20,
    parameter int ScanTime_ns    = 1_000_000,
    parameter int DebounceFrames = 3
) (
    input  logic           Clock,
    input  logic           ResetN,
    keypad_scan_if.master  kp
);

    localparam int RowPrescale = ScanTime_ns / ClockPeriod_ns / 4;
    localparam int PresW       = (RowPrescale > 1) ? $clog2(RowPrescale) : 1;
    localparam logic [PresW-1:0] PresLast = PresW'(RowPrescale - 1);
    localparam int CntW        = $clog2(DebounceFrames + 1);
    localparam logic [CntW-1:0] DebLast = CntW'(DebounceFrames);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    logic [PresW-1:0] pres;
    logic [1:0]       row_idx;
    logic [3:0]       rows_q;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [15:0]      frame;
    logic [15:0]      frame_now;
    logic             tick;
    logic             frame_done;
    logic             f_none;
    logic             f_many;
    logic             f_single;
    logic [3:0]       f_code;
    logic             cand_bit;

    state_t           state;
    logic [CntW-1:0]  cnt;
    logic [CntW-1:0]  cnt_inc;
    logic [3:0]       cand;
    logic [3:0]       key_q;
    logic             strobe_q;
    logic             held_q;
    logic             multi_q;

    assign kp.Rows   = rows_q;
    assign kp.Key    = key_q;
    assign kp.Strobe = strobe_q;
    assign kp.Held   = held_q;
    assign kp.Multi  = multi_q;

    // frame_now is the frame as it will look once the current row's columns
    // are merged in; classification on the last row slot must see all 16 bits.
    always_comb begin
        tick       = (pres == PresLast);
        frame_done = tick && (row_idx == 2'd3);
        frame_now  = frame;
        frame_now[{row_idx, 2'b00} +: 4] = ~sync2;
        f_none     = (frame_now == 16'd0);
        // x & (x-1) clears the lowest set bit: non-zero means two or more set
        f_many     = |(frame_now & (frame_now - 16'd1));
        f_single   = !f_none && !f_many;
        f_code     = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_now[i]) begin
                f_code = 4'(i);
            end
        end
        cand_bit   = frame_now[cand];
        cnt_inc    = cnt + CntOne;
    end

    // Row scanning, column synchronizer and frame accumulation
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            pres    <= '0;
            row_idx <= 2'd0;
            rows_q  <= 4'b1110;
            sync1   <= 4'b1111;
            sync2   <= 4'b1111;
            frame   <= 16'd0;
        end else begin
            sync1 <= kp.Cols;
            sync2 <= sync1;
            if (tick) begin
                pres    <= '0;
                row_idx <= row_idx + 2'd1;
                rows_q  <= ~(4'b0001 << (row_idx + 2'd1));
                frame   <= frame_done ? 16'd0 : frame_now;
            end else begin
                pres <= pres + 1'b1;
            end
        end
    end

    // Debounce FSM; all transitions happen on frame boundaries only
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state    <= IDLE;
            cnt      <= '0;
            cand     <= 4'd0;
            key_q    <= 4'd0;
            strobe_q <= 1'b0;
            held_q   <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (frame_done) begin
                multi_q <= f_many;
                case (state)
                    IDLE: begin
                        if (f_single) begin
                            cand <= f_code;
                            cnt  <= CntOne;
                            if (DebounceFrames == 1) begin
                                state    <= HELD;
                                key_q    <= f_code;
                                strobe_q <= 1'b1;
                                held_q   <= 1'b1;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (f_single && (f_code == cand)) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DebLast) begin
                                state    <= HELD;
                                key_q    <= cand;
                                strobe_q <= 1'b1;
                                held_q   <= 1'b1;
                            end
                        end else if (f_single) begin
                            cand <= f_code;
                            cnt  <= CntOne;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        // the accepted key may still be present inside a multi-key frame
                        if (!cand_bit) begin
                            if (DebounceFrames == 1) begin
                                state  <= IDLE;
                                held_q <= 1'b0;
                            end else begin
                                state <= RELEASE;
                                cnt   <= CntOne;
                            end
                        end
                    end
                    RELEASE: begin
                        if (!cand_bit) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DebLast) begin
                                state  <= IDLE;
                                held_q <= 1'b0;
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan with frame-level reference model
module tb_keypad_scan;

    localparam int D = 3;
    localparam int P_IDLE = 0;
    localparam int P_DEB  = 1;
    localparam int P_DOWN = 2;
    localparam int P_REL  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = 16'd0;

    int checks = 0;
    int failures = 0;
    int frame_cnt = 0;
    int strobe_cnt = 0;
    logic [3:0] last_rows = 4'b1110;

    int         m_phase = P_IDLE;
    int         m_run = 0;
    logic [3:0] m_cand = 4'd0;
    logic [3:0] m_key = 4'd0;
    logic       m_multi = 1'b0;

    always #10 clk = ~clk;

    keypad_scan_if kp ();

    keypad_scan #(
        .ClockPeriod_ns (20),
        .ScanTime_ns    (320),
        .DebounceFrames (D)
    ) dut (
        .Clock  (clk),
        .ResetN (rst_n),
        .kp     (kp)
    );

    // Matrix model: a pressed key pulls its column low while its row is driven
    always_comb begin
        kp.Cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kp.Rows[r] && keys[r*4+c]) begin
                    kp.Cols[c] = 1'b0;
                end
            end
        end
    end

    // Frame boundary = Rows wrapping from row 3 back to row 0
    always @(negedge clk) begin
        if (!rst_n) begin
            last_rows = 4'b1110;
        end else begin
            if (kp.Rows == 4'b1110 && last_rows == 4'b0111) frame_cnt++;
            if (kp.Strobe) strobe_cnt++;
            last_rows = kp.Rows;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_run   = 0;
        m_cand  = 4'd0;
        m_key   = 4'd0;
        m_multi = 1'b0;
    endtask

    // One whole frame with a stable set of pressed keys
    task automatic model_step(input logic [15:0] f, output int stb);
        int n;
        logic [3:0] code;
        n    = $countones(f);
        code = (n == 1) ? 4'($clog2(f)) : 4'd0;
        stb  = 0;
        case (m_phase)
            P_IDLE: if (n == 1) begin
                m_cand = code;
                m_run  = 1;
                if (m_run == D) begin m_phase = P_DOWN; m_key = code; stb = 1; end
                else m_phase = P_DEB;
            end
            P_DEB: begin
                if (n == 1 && code == m_cand) begin
                    m_run++;
                    if (m_run == D) begin m_phase = P_DOWN; m_key = m_cand; stb = 1; end
                end else if (n == 1) begin
                    m_cand = code;
                    m_run  = 1;
                end else begin
                    m_phase = P_IDLE;
                end
            end
            P_DOWN: if (!f[m_cand]) begin
                if (D == 1) m_phase = P_IDLE;
                else begin m_phase = P_REL; m_run = 1; end
            end
            default: begin
                if (!f[m_cand]) begin
                    m_run++;
                    if (m_run == D) m_phase = P_IDLE;
                end else begin
                    m_phase = P_DOWN;
                end
            end
        endcase
        m_multi = (n > 1);
    endtask

    task automatic check_frame(input logic [15:0] f, input int s0);
        int stb;
        model_step(f, stb);
        chk("strobe_count", 32'(strobe_cnt - s0), 32'(stb));
        chk("key", 32'(kp.Key), 32'(m_key));
        chk("held", 32'(kp.Held), 32'(m_phase == P_DOWN || m_phase == P_REL));
        chk("multi", 32'(kp.Multi), 32'(m_multi));
    endtask

    task automatic run_frame(input logic [15:0] f);
        int target;
        int s0;
        keys   = f;
        target = frame_cnt + 1;
        s0     = strobe_cnt;
        for (int i = 0; i < 40 && frame_cnt < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (frame_cnt < target) chk("frame_timeout", 32'(frame_cnt), 32'(target));
        check_frame(f, s0);
    endtask

    initial begin
        logic [3:0]  exp_rows;
        logic [15:0] prev;
        logic [15:0] f;
        int          s0;
        int          sel;

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rows", 32'(kp.Rows), 32'h0000000E);
        chk("rst_key", 32'(kp.Key), 0);
        chk("rst_strobe", 32'(kp.Strobe), 0);
        chk("rst_held", 32'(kp.Held), 0);
        chk("rst_multi", 32'(kp.Multi), 0);

        // Idle scan sequence, row changes every 4 cycles
        @(negedge clk);
        rst_n = 1'b1;
        s0 = strobe_cnt;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            #1;
            if (k % 4 == 0) begin
                exp_rows = ~(4'b0001 << ((k / 4) % 4));
                chk("scan_rows", 32'(kp.Rows), 32'(exp_rows));
            end
        end
        check_frame(16'd0, s0);

        // Key 6 pressed for three frames, then released for three
        for (int i = 0; i < 3; i++) run_frame(16'h0040);
        chk("press6_key", 32'(kp.Key), 6);
        for (int i = 0; i < 3; i++) run_frame(16'h0000);
        chk("release6_key", 32'(kp.Key), 6);

        // Key 6 present 1, absent 1, present 3
        run_frame(16'h0040);
        run_frame(16'h0000);
        for (int i = 0; i < 3; i++) run_frame(16'h0040);
        for (int i = 0; i < 3; i++) run_frame(16'h0000);

        // Reset in the middle of debouncing key 9
        run_frame(16'h0200);
        run_frame(16'h0200);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #2;
        chk("midrst_rows", 32'(kp.Rows), 32'h0000000E);
        chk("midrst_key", 32'(kp.Key), 0);
        chk("midrst_held", 32'(kp.Held), 0);
        chk("midrst_strobe", 32'(kp.Strobe), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) run_frame(16'h0200);
        chk("press9_key", 32'(kp.Key), 9);
        for (int i = 0; i < 3; i++) run_frame(16'h0000);

        // Keys 0 and 15 together, then release 15
        run_frame(16'h8001);
        chk("multi_0_15", 32'(kp.Multi), 1);
        run_frame(16'h8001);
        for (int i = 0; i < 3; i++) run_frame(16'h0001);
        chk("press0_key", 32'(kp.Key), 0);
        for (int i = 0; i < 3; i++) run_frame(16'h0000);

        // Randomized frames
        prev = 16'd0;
        for (int n = 0; n < 120; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3) f = prev;
            else if (sel <= 5) f = 16'd0;
            else if (sel <= 7) f = 16'(1 << $urandom_range(0, 15));
            else if (sel == 8) f = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
            else f = prev | 16'(1 << $urandom_range(0, 15));
            run_frame(f);
            prev = f;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
